erode_stream: RTL and testbench
===============================

// Module: erode_stream
// PURPOSE
//  Streaming binary erosion, the dual of the dilation node: consumes a raster-order 1-bit pixel stream,
//  builds a Width x Height window from Height-1 line buffers plus a shift window, and emits
//  Q = AND over window of (~element | pixel), with no reflection of element.
//  Sits between the binarised pixel source and the fitness/compare stage of the morphology pipeline.
// PARAMETERS
//  Width     3    structuring-element / window columns (>=1)
//  Height    3    structuring-element / window rows (>=1)
//  ImgWidth  640  pixels per input line (>=Width)
//  ImgHeight 480  lines per input frame (>=Height)
// PORTS
//  clk        in   1               single clock, all logic rising-edge
//  rst        in   1               synchronous, active-high reset
//  element    in   Width*Height    structuring element, bit l*Width+c = row l (0=top), col c (0=left); static within a frame
//  in_valid   in   1               in_pixel valid this cycle (no backpressure)
//  in_sof     in   1               qualifies in_valid: this pixel is (row0,col0) of a new frame
//  in_pixel   in   1               binary pixel, raster order
//  out_valid  out  1               out_pixel valid
//  out_pixel  out  1               eroded pixel
//  out_eof    out  1               with out_valid: last output pixel of the frame
// BEHAVIOUR
//  - Reset: out_valid=0, out_pixel=0, out_eof=0, row/col counters=0. Line buffer and window contents are
//    not reset; outputs are gated so stale contents are never emitted.
//  - Per accepted pixel (in_valid=1): shift in_pixel into window row Height-1 and line buffer 0; each line
//    buffer tail feeds the next row up. Window bit l*Width+c holds the pixel at (r-(Height-1-l), k-(Width-1-c)),
//    where (r,k) is the current input position.
//  - Counters: col increments per accepted pixel and wraps ImgWidth-1 -> 0, incrementing row; row wraps
//    ImgHeight-1 -> 0. in_sof=1 with in_valid forces the pixel's position to (0,0), whatever the counter state.
//    in_sof without in_valid is ignored.
//  - Output: exactly 1 cycle after an accepted pixel at (r,k) with r>=Height-1 and k>=Width-1:
//    out_valid=1, out_pixel=&(~element | window_incl_this_pixel). Otherwise out_valid=0 and out_pixel holds
//    its previous value. Output frame is (ImgWidth-Width+1) x (ImgHeight-Height+1); no padding.
//  - out_eof=1 only with the output for input (ImgHeight-1, ImgWidth-1).
//  - in_valid gaps: the state freezes; the window never advances without in_valid.
//  - element=0: every valid output is 1. element all ones: output is the plain AND of the window.
//  - Window columns spanning a line wrap are never output, because the k>=Width-1 gate blocks them.
//  - rst mid-frame: outputs drop to 0 next cycle. The next pixel is treated as (0,0) even without in_sof.
//  - in_sof mid-frame: the current frame is abandoned with no out_eof, and the new frame starts at that pixel.
// STRUCTURE
//  - Shared package morph_pkg: window index function idx(l,c)=l*Width+c, and localparams for the counter
//    widths $clog2(ImgWidth) and $clog2(ImgHeight). The same package is used by DilateNode users.
//  - Sub-module erode_node (combinational, params Width/Height, ports element, D, Q) computes the AND
//    reduction. erode_stream owns the counters, line buffers (Height-1 shift regs of ImgWidth bits), window
//    regs and output register.
// TESTING (Width=3, Height=3, ImgWidth=8, ImgHeight=6 unless noted)
//  - All-ones frame, element=9'h1FF -> 24 outputs, all 1. out_eof on the 24th only. First out_valid is
//    1 cycle after pixel (2,2).
//  - All-ones frame with single 0 at (3,4), element=cross 9'h0BA -> exactly the outputs whose windows
//    cover (3,4) via a cross bit are 0: the centre (3,4) and its 4-neighbours. All others are 1.
//  - element=0, random frame -> all 24 outputs are 1.
//  - Random in_valid gaps (~50% duty) on a random frame, element=9'h1FF -> output sequence identical
//    to the gap-free run.
//  - in_sof asserted at pixel (4,3) mid-frame, then a full frame -> no out_eof for the aborted frame;
//    exactly 24 outputs for the new frame, matching the model.
//  - rst pulsed mid-frame (at pixel (3,5)) -> out_valid=0 the next cycle. The subsequent 48 pixels
//    produce 24 correct outputs with out_eof on the last.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared helpers for the streaming morphology nodes (erosion and dilation).
// Window bits are addressed as row*Width+col, with row 0 at the top and col 0 at the left.
// The counter widths are sized for the largest supported image.
package morph_pkg;

   localparam int MaxImgWidth  = 640;
   localparam int MaxImgHeight = 480;

   localparam int ColCntW = $clog2(MaxImgWidth);
   localparam int RowCntW = $clog2(MaxImgHeight);

   // Flat index of window row l, column c for a window that is w columns wide.
   function automatic int idx(input int l, input int c, input int w);
      return l * w + c;
   endfunction

endpackage

// File: rtl/erode_node.sv
// Combinational erosion kernel.
// Every position the structuring element cares about must see a 1; positions outside the
// element are don't-care. The element is not reflected.
module erode_node #(
   parameter int Width  = 3,
   parameter int Height = 3
) (
   input  logic [Width*Height-1:0] element,
   input  logic [Width*Height-1:0] D,
   output logic                    Q
);

   // A window position vetoes the result only if the element uses it and the pixel there is 0.
   always_comb begin
      Q = 1'b1;
      for (int i = 0; i < Width*Height; i++) begin
         if (element[i] && !D[i]) begin
            Q = 1'b0;
         end
      end
   end

endmodule

// File: rtl/erode_stream.sv
// Streaming binary erosion over a raster-order 1-bit pixel stream.
// Height-1 line buffers delay the stream by whole lines. Their tails, together with the live
// pixel, feed a Width x Height shift window. An output is produced only where the whole window
// lies inside the current frame. The image width must not exceed MaxImgWidth, and the image
// height must not exceed MaxImgHeight.
module erode_stream
   import morph_pkg::*;
#(
   parameter int Width     = 3,
   parameter int Height    = 3,
   parameter int ImgWidth  = 640,
   parameter int ImgHeight = 480
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [Width*Height-1:0] element,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic                    in_pixel,
   output logic                    out_valid,
   output logic                    out_pixel,
   output logic                    out_eof
);

   localparam int WinBits  = Width * Height;
   localparam int NumLines = (Height > 1) ? Height - 1 : 1;

   logic [ColCntW-1:0]  r_col;
   logic [RowCntW-1:0]  r_row;
   logic [ColCntW-1:0]  w_col;
   logic [RowCntW-1:0]  w_row;
   logic [ColCntW-1:0]  w_colNext;
   logic [RowCntW-1:0]  w_rowNext;

   logic [ImgWidth-1:0] r_lineBuf [NumLines];
   logic [WinBits-1:0]  r_window;
   logic [WinBits-1:0]  w_window;
   logic [Height-1:0]   w_rowFeed;

   logic                w_gate;
   logic                w_eof;
   logic                w_q;

   logic                r_outValid;
   logic                r_outPixel;
   logic                r_outEof;

   // Position of the pixel on the input this cycle; a start-of-frame pixel is always (0,0).
   // This block also computes where the next pixel will land.
   always_comb begin
      w_col     = in_sof ? '0 : r_col;
      w_row     = in_sof ? '0 : r_row;
      w_colNext = w_col + ColCntW'(1);
      w_rowNext = w_row;
      if (w_col == ColCntW'(ImgWidth - 1)) begin
         w_colNext = '0;
         if (w_row == RowCntW'(ImgHeight - 1)) begin
            w_rowNext = '0;
         end else begin
            w_rowNext = w_row + RowCntW'(1);
         end
      end
   end

   // Output is allowed only when the full window lies inside the frame.
   // That blocks the first rows and the columns that straddle a line wrap.
   always_comb begin
      w_gate = (w_row >= RowCntW'(Height - 1)) && (w_col >= ColCntW'(Width - 1));
      w_eof  = (w_row == RowCntW'(ImgHeight - 1)) && (w_col == ColCntW'(ImgWidth - 1));
   end

   // The newest column entering each window row: the live pixel at the bottom, and
   // line-buffer tails (one line older per buffer) for the rows above.
   always_comb begin
      w_rowFeed             = '0;
      w_rowFeed[Height - 1] = in_pixel;
      for (int m = 1; m < Height; m++) begin
         w_rowFeed[Height - 1 - m] = r_lineBuf[m - 1][ImgWidth - 1];
      end
   end

   // Window as it looks after accepting this pixel: every row shifts one column left,
   // and the newest pixel of each row lands in column Width-1.
   always_comb begin
      w_window = r_window;
      for (int l = 0; l < Height; l++) begin
         for (int c = 0; c < Width; c++) begin
            if (c < Width - 1) begin
               w_window[idx(l, c, Width)] = r_window[idx(l, c + 1, Width)];
            end else begin
               w_window[idx(l, c, Width)] = w_rowFeed[l];
            end
         end
      end
   end

   erode_node #(
      .Width  (Width),
      .Height (Height)
   ) u_erodeNode (
      .element (element),
      .D       (w_window),
      .Q       (w_q)
   );

   // Pixel storage is deliberately not reset.
   // The output gate guarantees that stale contents never reach the output.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_window <= w_window;
         for (int m = 0; m < NumLines; m++) begin
            for (int i = ImgWidth - 1; i > 0; i--) begin
               r_lineBuf[m][i] <= r_lineBuf[m][i - 1];
            end
         end
         r_lineBuf[0][0] <= in_pixel;
         for (int m = 1; m < NumLines; m++) begin
            r_lineBuf[m][0] <= r_lineBuf[m - 1][ImgWidth - 1];
         end
      end
   end

   // Raster counters and the output register.
   // The counters advance only on accepted pixels. out_pixel holds its value between outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_outValid <= 1'b0;
         r_outPixel <= 1'b0;
         r_outEof   <= 1'b0;
      end else begin
         r_outValid <= 1'b0;
         r_outEof   <= 1'b0;
         if (in_valid) begin
            r_col <= w_colNext;
            r_row <= w_rowNext;
            if (w_gate) begin
               r_outValid <= 1'b1;
               r_outPixel <= w_q;
               r_outEof   <= w_eof;
            end
         end
      end
   end

   assign out_valid = r_outValid;
   assign out_pixel = r_outPixel;
   assign out_eof   = r_outEof;

endmodule

// File: tb/tb_erode_stream.sv
// Self-checking bench for erode_stream on a 3x3 window over an 8x6 image.
// The reference model tracks the raster position and the image received so far.
// It computes every output directly from the erosion rule.
module tb_erode_stream;

   localparam int W  = 3;
   localparam int H  = 3;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int OutPerFrame = (IW - W + 1) * (IH - H + 1);

   logic           clk = 1'b0;
   logic           rst;
   logic [W*H-1:0] element;
   logic           in_valid;
   logic           in_sof;
   logic           in_pixel;
   logic           out_valid;
   logic           out_pixel;
   logic           out_eof;

   erode_stream #(
      .Width     (W),
      .Height    (H),
      .ImgWidth  (IW),
      .ImgHeight (IH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .element   (element),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_pixel (out_pixel),
      .out_eof   (out_eof)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;

   logic img   [IH][IW];
   logic frame [IH][IW];
   int   posR;
   int   posK;
   logic lastPix;

   int   outCount;
   int   onesCount;
   int   eofCount;
   logic outSeq[$];
   logic refSeq[$];

   typedef struct {
      logic [W*H-1:0] elem;
      int             mode;
      int             zr;
      int             zk;
      bit             newFrame;
      bit             gaps;
      int             expOnes;
      bit             cmpPrev;
   } frameCase_t;

   frameCase_t cases[5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic p);
      logic expV;
      logic expP;
      logic expE;
      int   r;
      int   k;
      in_valid = v;
      in_sof   = s;
      in_pixel = p;
      expV = 1'b0;
      expP = lastPix;
      expE = 1'b0;
      if (v) begin
         r = s ? 0 : posR;
         k = s ? 0 : posK;
         img[r][k] = p;
         if (r >= H - 1 && k >= W - 1) begin
            expV = 1'b1;
            expP = 1'b1;
            for (int l = 0; l < H; l++) begin
               for (int c = 0; c < W; c++) begin
                  if (element[l*W + c] && !img[r - (H - 1) + l][k - (W - 1) + c]) begin
                     expP = 1'b0;
                  end
               end
            end
            expE = (r == IH - 1) && (k == IW - 1);
         end
         k++;
         if (k == IW) begin
            k = 0;
            r++;
            if (r == IH) begin
               r = 0;
            end
         end
         posR = r;
         posK = k;
      end
      @(negedge clk);
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expV});
      checkOutput("out_pixel", {31'd0, out_pixel}, {31'd0, expP});
      checkOutput("out_eof", {31'd0, out_eof}, {31'd0, expE});
      if (out_valid === 1'b1) begin
         outSeq.push_back(out_pixel);
         outCount++;
         if (out_pixel === 1'b1) onesCount++;
         if (out_eof === 1'b1) eofCount++;
      end
      lastPix = expP;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic clearStats();
      outCount  = 0;
      onesCount = 0;
      eofCount  = 0;
      outSeq.delete();
   endtask

   task automatic fillRandom();
      for (int r = 0; r < IH; r++)
         for (int k = 0; k < IW; k++)
            frame[r][k] = ($urandom_range(0, 3) != 0);
   endtask

   // Sends the first count pixels of frame; sofFirst marks the first of them as start of frame.
   task automatic sendPixels(input int count, input bit sofFirst, input bit gaps);
      int n;
      n = 0;
      for (int r = 0; r < IH; r++) begin
         for (int k = 0; k < IW; k++) begin
            if (n < count) begin
               if (gaps) begin
                  for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idleCycle();
               end
               applyStimulus(1'b1, 1'(sofFirst && n == 0), frame[r][k]);
               n++;
            end
         end
      end
   endtask

   task automatic checkFrame(input int expOnes, input bit cmpPrev);
      checkOutput("frame_count", outCount, OutPerFrame);
      checkOutput("frame_eof_count", eofCount, 1);
      if (expOnes >= 0) checkOutput("frame_ones", onesCount, expOnes);
      if (cmpPrev) begin
         checkOutput("gap_seq_len", outSeq.size(), refSeq.size());
         for (int i = 0; i < outSeq.size() && i < refSeq.size(); i++)
            checkOutput("gap_seq", {31'd0, outSeq[i]}, {31'd0, refSeq[i]});
      end
      refSeq = outSeq;
   endtask

   task automatic resetPulse();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_pixel", {31'd0, out_pixel}, 32'd0);
      checkOutput("rst_eof", {31'd0, out_eof}, 32'd0);
      rst     = 1'b0;
      posR    = 0;
      posK    = 0;
      lastPix = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = 1'b0;
      element  = '1;
      posR     = 0;
      posK     = 0;
      lastPix  = 1'b0;

      cases[0] = '{elem: 9'h1FF, mode: 0, zr: 0, zk: 0, newFrame: 1, gaps: 0, expOnes: 24, cmpPrev: 0};
      cases[1] = '{elem: 9'h0BA, mode: 1, zr: 3, zk: 4, newFrame: 1, gaps: 0, expOnes: 19, cmpPrev: 0};
      cases[2] = '{elem: 9'h000, mode: 2, zr: 0, zk: 0, newFrame: 1, gaps: 0, expOnes: 24, cmpPrev: 0};
      cases[3] = '{elem: 9'h1FF, mode: 2, zr: 0, zk: 0, newFrame: 1, gaps: 0, expOnes: -1, cmpPrev: 0};
      cases[4] = '{elem: 9'h1FF, mode: 2, zr: 0, zk: 0, newFrame: 0, gaps: 1, expOnes: -1, cmpPrev: 1};

      @(negedge clk);
      resetPulse();

      for (int i = 0; i < 5; i++) begin
         element = cases[i].elem;
         if (cases[i].newFrame) begin
            if (cases[i].mode == 2) begin
               fillRandom();
            end else begin
               for (int r = 0; r < IH; r++)
                  for (int k = 0; k < IW; k++)
                     frame[r][k] = 1'b1;
               if (cases[i].mode == 1) frame[cases[i].zr][cases[i].zk] = 1'b0;
            end
         end
         clearStats();
         sendPixels(IW * IH, 1'b1, cases[i].gaps);
         repeat (2) idleCycle();
         checkFrame(cases[i].expOnes, cases[i].cmpPrev);
      end

      // A new frame starts mid-frame at pixel (4,3); the abandoned frame must not signal eof.
      element = 9'h0BA;
      fillRandom();
      clearStats();
      sendPixels(4 * IW + 3, 1'b1, 1'b0);
      checkOutput("abort_eof_count", eofCount, 0);
      fillRandom();
      clearStats();
      sendPixels(IW * IH, 1'b1, 1'b0);
      repeat (2) idleCycle();
      checkFrame(-1, 1'b0);

      // A reset at pixel (3,5) abandons the frame; the next pixel is (0,0) even without sof.
      element = 9'h1FF;
      fillRandom();
      clearStats();
      sendPixels(3 * IW + 5, 1'b1, 1'b0);
      resetPulse();
      fillRandom();
      clearStats();
      sendPixels(IW * IH, 1'b0, 1'b0);
      repeat (2) idleCycle();
      checkFrame(-1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
